// File: rtl/vga_bounce_box.sv
// Pixel stage behind the 640x480 timing generator: checkerboard, white border
// and a bouncing colour-cycling square, with syncs re-aligned to the RGB.
module vga_bounce_box #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int BOX_SIZE = 32
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       valid_in,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       sw_pause,
    input  logic [1:0] sw_speed,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam logic [10:0] MAX_X = 11'(H_RES - BOX_SIZE);
    localparam logic [10:0] MAX_Y = 11'(V_RES - BOX_SIZE);
    localparam logic [9:0]  CTR_X = 10'((H_RES - BOX_SIZE) / 2);
    localparam logic [9:0]  CTR_Y = 10'((V_RES - BOX_SIZE) / 2);
    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

    logic       vs_prev;
    logic       tick;
    logic [9:0] box_x, box_y;
    logic       dir_x, dir_y;
    logic [2:0] cidx;

    logic [9:0] nx, ny;
    logic       ndir_x, ndir_y;
    logic       hit_x, hit_y;
    logic [10:0] step;

    logic       s1_hs, s1_vs, s1_valid;
    logic [9:0] s1_h, s1_v;

    logic [11:0] box_rgb, pix_rgb;
    logic        in_box, on_border;

    assign tick = vsync_in & ~vs_prev;
    assign step = {9'd0, sw_speed} + 11'd1;

    // Each axis clamps at its wall and reverses; arithmetic in 11 bits so the
    // sum and compare can never wrap.
    always_comb begin
        nx     = box_x;
        ndir_x = dir_x;
        hit_x  = 1'b0;
        if (dir_x) begin
            if ({1'b0, box_x} + step >= MAX_X) begin
                nx     = MAX_X[9:0];
                ndir_x = 1'b0;
                hit_x  = 1'b1;
            end else begin
                nx = box_x + step[9:0];
            end
        end else begin
            if ({1'b0, box_x} <= step) begin
                nx     = '0;
                ndir_x = 1'b1;
                hit_x  = 1'b1;
            end else begin
                nx = box_x - step[9:0];
            end
        end
    end

    always_comb begin
        ny     = box_y;
        ndir_y = dir_y;
        hit_y  = 1'b0;
        if (dir_y) begin
            if ({1'b0, box_y} + step >= MAX_Y) begin
                ny     = MAX_Y[9:0];
                ndir_y = 1'b0;
                hit_y  = 1'b1;
            end else begin
                ny = box_y + step[9:0];
            end
        end else begin
            if ({1'b0, box_y} <= step) begin
                ny     = '0;
                ndir_y = 1'b1;
                hit_y  = 1'b1;
            end else begin
                ny = box_y - step[9:0];
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            vs_prev <= 1'b1;
            box_x   <= CTR_X;
            box_y   <= CTR_Y;
            dir_x   <= 1'b1;
            dir_y   <= 1'b1;
            cidx    <= 3'd1;
        end else begin
            vs_prev <= vsync_in;
            if (tick && !sw_pause) begin
                box_x <= nx;
                box_y <= ny;
                dir_x <= ndir_x;
                dir_y <= ndir_y;
                if (hit_x || hit_y)
                    cidx <= cidx + 3'd1;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_valid <= 1'b0;
            s1_h     <= '0;
            s1_v     <= '0;
        end else begin
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            s1_valid <= valid_in;
            s1_h     <= h_cnt;
            s1_v     <= v_cnt;
        end
    end

    always_comb begin
        if (cidx == 3'd0)
            box_rgb = '1;
        else
            box_rgb = {{4{cidx[0]}}, {4{cidx[1]}}, {4{cidx[2]}}};
    end

    assign in_box = ({1'b0, s1_h} >= {1'b0, box_x}) && ({1'b0, s1_h} < {1'b0, box_x} + BOX_W) &&
                    ({1'b0, s1_v} >= {1'b0, box_y}) && ({1'b0, s1_v} < {1'b0, box_y} + BOX_W);
    assign on_border = (s1_h == '0) || (s1_h == 10'(H_RES - 1)) ||
                       (s1_v == '0) || (s1_v == 10'(V_RES - 1));

    always_comb begin
        pix_rgb = '0;
        if (!s1_valid)
            pix_rgb = '0;
        else if (in_box)
            pix_rgb = box_rgb;
        else if (on_border)
            pix_rgb = '1;
        else if (s1_h[5] ^ s1_v[5])
            pix_rgb = 12'h333;
        else
            pix_rgb = 12'h111;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            hsync <= s1_hs;
            vsync <= s1_vs;
            vga_r <= pix_rgb[11:8];
            vga_g <= pix_rgb[7:4];
            vga_b <= pix_rgb[3:0];
        end
    end

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: pixel vector table plus bounce, pause,
// speed and reset sequences.
module tb_vga_bounce_box;

    logic       pclk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in, valid_in;
    logic [9:0] h_cnt, v_cnt;
    logic       sw_pause;
    logic [1:0] sw_speed;
    logic       hsync, vsync;
    logic [3:0] vga_r, vga_g, vga_b;

    int total = 0;
    int bad   = 0;

    vga_bounce_box #(.H_RES(640), .V_RES(480), .BOX_SIZE(32)) dut (
        .pclk(pclk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .valid_in(valid_in),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .sw_pause(sw_pause), .sw_speed(sw_speed),
        .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        hs;
        logic        valid;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [11:0] rgb;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_box(input string tag, input int x, input int y, input int c);
        chk({tag, " box_x"}, int'(dut.box_x), x);
        chk({tag, " box_y"}, int'(dut.box_y), y);
        chk({tag, " cidx"}, int'(dut.cidx), c);
    endtask

    // One short vsync pulse; box state is updated by the following negedge.
    task automatic frame_tick();
        @(negedge pclk);
        vsync_in = 1'b0;
        @(negedge pclk);
        vsync_in = 1'b1;
        @(negedge pclk);
    endtask

    task automatic pixel(input string name, input int h, input int v, input int exp);
        @(negedge pclk);
        valid_in = 1'b1;
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        @(negedge pclk);
        @(negedge pclk);
        chk(name, int'({vga_r, vga_g, vga_b}), exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t vecs[15];
        vecs[0]  = '{1'b1, 1'b1, 10'd0,   10'd100, 12'hFFF};
        vecs[1]  = '{1'b0, 1'b1, 10'd0,   10'd100, 12'hFFF};
        vecs[2]  = '{1'b1, 1'b0, 10'd0,   10'd100, 12'h000};
        vecs[3]  = '{1'b0, 1'b0, 10'd0,   10'd100, 12'h000};
        vecs[4]  = '{1'b1, 1'b1, 10'd40,  10'd8,   12'h333};
        vecs[5]  = '{1'b1, 1'b1, 10'd8,   10'd8,   12'h111};
        vecs[6]  = '{1'b1, 1'b1, 10'd335, 10'd255, 12'hF00};
        vecs[7]  = '{1'b1, 1'b1, 10'd336, 10'd255, 12'h333};
        vecs[8]  = '{1'b1, 1'b1, 10'd304, 10'd224, 12'hF00};
        vecs[9]  = '{1'b1, 1'b1, 10'd303, 10'd224, 12'h111};
        vecs[10] = '{1'b1, 1'b1, 10'd639, 10'd100, 12'hFFF};
        vecs[11] = '{1'b1, 1'b1, 10'd100, 10'd479, 12'hFFF};
        vecs[12] = '{1'b1, 1'b1, 10'd100, 10'd0,   12'hFFF};
        vecs[13] = '{1'b1, 1'b1, 10'd335, 10'd256, 12'h111};
        vecs[14] = '{1'b1, 1'b1, 10'd304, 10'd223, 12'h333};

        // Reset with random inputs
        reset = 1'b1;
        sw_pause = 1'b0;
        sw_speed = 2'd3;
        for (int i = 0; i < 4; i++) begin
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            valid_in = 1'($urandom);
            h_cnt = 10'($urandom);
            v_cnt = 10'($urandom);
            @(negedge pclk);
            chk("reset hsync", int'(hsync), 1);
            chk("reset vsync", int'(vsync), 1);
            chk("reset rgb", int'({vga_r, vga_g, vga_b}), 0);
        end
        chk_box("reset", 304, 224, 1);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        valid_in = 1'b0;
        @(negedge pclk);
        reset = 1'b0;

        // Pipelined table: vector j-2 is due on the outputs at step j
        for (int j = 0; j < 17; j++) begin
            @(negedge pclk);
            if (j >= 2) begin
                chk($sformatf("vec%0d hsync", j - 2), int'(hsync), int'(vecs[j - 2].hs));
                chk($sformatf("vec%0d vsync", j - 2), int'(vsync), 1);
                chk($sformatf("vec%0d rgb", j - 2), int'({vga_r, vga_g, vga_b}), int'(vecs[j - 2].rgb));
            end
            if (j < 15) begin
                hsync_in = vecs[j].hs;
                valid_in = vecs[j].valid;
                h_cnt = vecs[j].h;
                v_cnt = vecs[j].v;
            end else begin
                hsync_in = 1'b1;
                valid_in = 1'b0;
            end
        end
        chk_box("after table", 304, 224, 1);

        // vsync latency: low pulse shows up on vsync exactly two cycles later
        @(negedge pclk);
        vsync_in = 1'b0;
        @(negedge pclk);
        vsync_in = 1'b1;
        chk("vsync lat1", int'(vsync), 1);
        @(negedge pclk);
        chk("vsync lat2", int'(vsync), 0);
        @(negedge pclk);
        chk("vsync lat3", int'(vsync), 1);
        chk_box("tick1", 308, 228, 1);

        // Bounce at step 4
        for (int t = 2; t <= 168; t++) begin
            frame_tick();
            if (t == 55) chk_box("tick55", 304 + 4 * 55, 444, 1);
            if (t == 56) begin
                chk_box("tick56", 304 + 4 * 56, 448, 2);
                chk("tick56 dir_y", int'(dut.dir_y), 0);
            end
            if (t == 76) begin
                chk_box("tick76", 608, 368, 3);
                chk("tick76 dir_x", int'(dut.dir_x), 0);
            end
            if (t == 168) begin
                chk_box("tick168", 240, 0, 4);
                chk("tick168 dir_y", int'(dut.dir_y), 1);
            end
        end
        pixel("blue box over border", 240, 0, 12'h00F);

        // Pause, with speed wiggling between ticks
        sw_pause = 1'b1;
        for (int t = 0; t < 10; t++) begin
            sw_speed = 2'(t);
            frame_tick();
        end
        chk_box("paused", 240, 0, 4);
        sw_pause = 1'b0;
        sw_speed = 2'd0;
        frame_tick();
        chk_box("speed1", 239, 1, 4);

        sw_speed = 2'd3;
        for (int t = 0; t < 30; t++) frame_tick();

        // Mid-line asynchronous reset
        @(negedge pclk);
        valid_in = 1'b1;
        h_cnt = 10'd100;
        v_cnt = 10'd0;
        @(negedge pclk);
        @(negedge pclk);
        chk("pre-reset rgb", int'({vga_r, vga_g, vga_b}), 12'hFFF);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk_box("mid reset", 304, 224, 1);
        @(negedge pclk);
        chk("held reset rgb", int'({vga_r, vga_g, vga_b}), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge pclk);
        chk_box("post reset", 304, 224, 1);
        chk("post reset dir_x", int'(dut.dir_x), 1);
        pixel("post reset box", 304, 224, 12'hF00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
